// File: rtl/direct_codec_pkg.sv
// Shared definitions for the direct codec: codeword layout {data, marker},
// lock-state type and the encoder-side reference function.
package direct_codec_pkg;
  localparam int CW_DATA_WIDTH   = 8;
  localparam int CW_MARKER_WIDTH = 4;
  localparam int CW_WIDTH        = CW_DATA_WIDTH + CW_MARKER_WIDTH;
  localparam logic [CW_MARKER_WIDTH-1:0] CW_MARKER = 4'b1010;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lock_state_t;

  function automatic logic [CW_DATA_WIDTH-1:0] cw_data(input logic [CW_WIDTH-1:0] cw);
    return cw[CW_WIDTH-1:CW_MARKER_WIDTH];
  endfunction

  function automatic logic [CW_MARKER_WIDTH-1:0] cw_marker(input logic [CW_WIDTH-1:0] cw);
    return cw[CW_MARKER_WIDTH-1:0];
  endfunction

  function automatic logic [CW_WIDTH-1:0] encode(input logic [CW_DATA_WIDTH-1:0] d);
    return {d, CW_MARKER};
  endfunction
endpackage

// File: rtl/direct_lock_fsm.sv
// Marker-lock FSM: counts consecutive good markers to lock and consecutive
// bad markers to drop back to search.
module direct_lock_fsm
  import direct_codec_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_i,
  input  logic        good_i,
  output lock_state_t state_o,
  output logic        locked_o
);
  lock_state_t state_q, state_d;
  logic [3:0]  good_run_q, good_run_d;
  logic [3:0]  bad_run_q, bad_run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      good_run_q <= '0;
      bad_run_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      bad_run_q  <= bad_run_d;
    end
  end

  // Run counters compared one bit wider so "reaches count" never wraps.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    if (acc_i) begin
      case (state_q)
        SEARCH: begin
          if (!good_i) begin
            good_run_d = '0;
          end else if (({1'b0, good_run_q} + 5'd1) == 5'(LOCK_COUNT)) begin
            state_d    = LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            good_run_d = good_run_q + 4'd1;
          end
        end
        default: begin
          if (good_i) begin
            bad_run_d = '0;
          end else if (({1'b0, bad_run_q} + 5'd1) == 5'(UNLOCK_COUNT)) begin
            state_d    = SEARCH;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            bad_run_d = bad_run_q + 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    locked_o = (state_q == LOCKED);
  end
endmodule

// File: rtl/direct_decoder_stream.sv
// Direct decoder: checks codeword markers, tracks lock and forwards payloads
// accepted while locked through a single valid/ready output register.
module direct_decoder_stream
  import direct_codec_pkg::*;
#(
  parameter int DATA_WIDTH    = CW_DATA_WIDTH,
  parameter int MARKER_WIDTH  = CW_MARKER_WIDTH,
  parameter logic [MARKER_WIDTH-1:0] MARKER = CW_MARKER,
  parameter int LOCK_COUNT    = 3,
  parameter int UNLOCK_COUNT  = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH+MARKER_WIDTH-1:0]   in_codeword,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_marker_err,
  output logic                                 locked,
  output logic [ERR_CNT_WIDTH-1:0]             err_count,
  input  logic                                 clr_count
);
  lock_state_t            state;
  logic                   acc, good, load;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_err_q, out_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  direct_lock_fsm #(
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (acc),
    .good_i   (good),
    .state_o  (state),
    .locked_o (locked)
  );

  // Search consumes every word; locked backpressures via the output register.
  assign in_ready = (state == LOCKED) ? (!out_valid_q | out_ready) : 1'b1;
  assign acc      = in_valid & in_ready;
  assign good     = (in_codeword[MARKER_WIDTH-1:0] == MARKER);
  assign load     = acc & (state == LOCKED);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_codeword[DATA_WIDTH+MARKER_WIDTH-1:MARKER_WIDTH];
      out_err_d   = !good;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_count)                         err_d = '0;
    else if (acc && !good && err_q != '1)  err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      err_q       <= err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_marker_err = out_err_q;
  assign err_count      = err_q;
endmodule

// File: tb/tb_direct_decoder_stream.sv
// Scoreboard bench for direct_decoder_stream: directed lock/backpressure/
// unlock sequences followed by randomized traffic against a reference model.
module tb_direct_decoder_stream;
  import direct_codec_pkg::*;

  localparam int EW      = 3;
  localparam int LOCKN   = 3;
  localparam int UNLOCKN = 2;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [11:0]   in_codeword;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_marker_err;
  logic          locked;
  logic [EW-1:0] err_count;
  logic          clr_count;

  direct_decoder_stream #(
    .LOCK_COUNT    (LOCKN),
    .UNLOCK_COUNT  (UNLOCKN),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_codeword    (in_codeword),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_marker_err (out_marker_err),
    .locked         (locked),
    .err_count      (err_count),
    .clr_count      (clr_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic e; } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  bit   m_locked;
  int   m_good_run, m_bad_run, m_err;
  bit   rand_or = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model + monitor; the output register is occupied exactly when
  // the scoreboard holds an undelivered word.
  always @(negedge clk) begin
    bit   exp_rdy, acc, good;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_locked = 0; m_good_run = 0; m_bad_run = 0; m_err = 0;
    end else begin
      exp_rdy = !m_locked || q.size() == 0 || out_ready;
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_marker_err", 32'(out_marker_err), 32'(e.e));
      end
      acc  = in_valid && exp_rdy;
      good = (in_codeword[3:0] == CW_MARKER);
      if (acc) begin
        if (m_locked) begin
          q.push_back('{d: in_codeword[11:4], e: !good});
          if (good) m_bad_run = 0;
          else if (++m_bad_run == UNLOCKN) begin
            m_locked = 0; m_bad_run = 0; m_good_run = 0;
          end
        end else if (good) begin
          if (++m_good_run == LOCKN) begin
            m_locked = 1; m_good_run = 0; m_bad_run = 0;
          end
        end else m_good_run = 0;
      end
      if (clr_count) m_err = 0;
      else if (acc && !good && m_err < ERR_MAX) m_err++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [11:0] cw);
    int  n = 0;
    bit  taken;
    in_valid = 1'b1; in_codeword = cw;
    forever begin
      @(negedge clk); taken = in_ready;
      @(posedge clk); #1;
      if (taken) break;
      if (++n > 500) begin
        n_chk++;
        $display("FAIL send_timeout: codeword %0h not accepted within 500 cycles", cw);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; clr_count = 1'b0;
    #2;
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_out_data", 32'(out_data), 0);
    chk("init_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    // Lock acquisition, then first forwarded word.
    send(12'hAAA); send(12'h55A); send(12'hF0A); send(12'h3CA);
    repeat (2) @(posedge clk); #1;
    // Backpressure: second word waits until the sink opens.
    out_ready = 1'b0;
    send(12'h11A);
    fork send(12'h22A); join_none
    repeat (4) @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    // Single error while locked, then clean word.
    send(12'h77B); send(12'h78A);
    // Loss of lock; the following good word is swallowed.
    send(12'h010); send(12'h020); send(12'h99A);
    // Saturation in search, then clear colliding with a bad accept.
    for (int i = 0; i < 8; i++) send(12'h005);
    clr_count = 1'b1; send(12'h006); clr_count = 1'b0;
    repeat (2) @(posedge clk); #1;
    do_reset();

    rand_or = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [11:0] cw;
      if (i == 200) begin
        rand_or = 1'b0; do_reset(); rand_or = 1'b1;
      end
      cw = encode(8'($urandom));
      if ($urandom_range(0, 9) < 3) cw[3:0] = 4'($urandom);
      clr_count = ($urandom_range(0, 24) == 0);
      send(cw);
      clr_count = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_or = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/direct_decoder_stream.md
Name: direct_decoder_stream

Overview:
- Downstream consumer of the direct encoder. It receives 12-bit codewords laid out as {data[7:0], marker 4'b1010} and checks the 4-bit marker.
- Runs a marker-lock state machine and forwards the recovered 8-bit payload through a registered valid/ready stage.
- Sits between the channel model or encoder output and the payload sink. It also provides lock and error statistics for the testbench scoreboard.

Parameters:
- DATA_WIDTH, 8, payload width; codeword bits [DATA_WIDTH+MARKER_WIDTH-1:MARKER_WIDTH].
- MARKER_WIDTH, 4, width of the fixed marker field in codeword bits [MARKER_WIDTH-1:0].
- MARKER, 4'b1010, expected marker value.
- LOCK_COUNT, 3, consecutive good markers needed to go SEARCH->LOCKED (legal range 1..15).
- UNLOCK_COUNT, 2, consecutive bad markers needed to go LOCKED->SEARCH (legal range 1..15).
- ERR_CNT_WIDTH, 16, width of the saturating marker-error counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, codeword valid.
- in_ready, output, 1, block can accept a codeword.
- in_codeword, input, DATA_WIDTH+MARKER_WIDTH, codeword from the encoder.
- out_valid, output, 1, payload valid.
- out_ready, input, 1, sink accepts the payload.
- out_data, output, DATA_WIDTH, recovered payload.
- out_marker_err, output, 1, the forwarded word had a bad marker.
- locked, output, 1, FSM is in LOCKED.
- err_count, output, ERR_CNT_WIDTH, total bad markers accepted.
- clr_count, input, 1, synchronous clear of err_count.

Behaviour:
- Reset (async, rst_n=0) forces:
  - out_valid=0, out_data=0, out_marker_err=0.
  - locked=0, FSM=SEARCH.
  - Good and bad run counters=0, err_count=0.
  - in_ready reflects the reset state, so it is 1.
- Reset mid-operation discards any held output word immediately. No partial state survives.
- Accept event: acc = in_valid & in_ready.
- good = (in_codeword[MARKER_WIDTH-1:0] == MARKER), evaluated only on acc.
- In SEARCH, in_ready=1 always. Accepted words are consumed and never forwarded.
  - On acc & good: good_run++. When good_run reaches LOCK_COUNT, go to LOCKED next cycle and clear both run counters.
  - On acc & !good: good_run=0.
- In LOCKED, in_ready = !out_valid | out_ready (single-register pipeline; full throughput under continuous out_ready).
  - Every accepted word is loaded into the output register on the next edge: out_data = codeword payload bits, out_marker_err = !good, out_valid=1.
  - On acc & good: bad_run=0.
  - On acc & !good: bad_run++. When bad_run reaches UNLOCK_COUNT, go to SEARCH and clear both run counters. The word that triggers the unlock is still forwarded, with out_marker_err=1.
- Forwarding decision uses the state at the time of acceptance:
  - The word that completes lock is not forwarded.
  - The first forwarded word is the next one accepted.
- Output register:
  - out_valid deasserts only when out_valid & out_ready & !(a new word is loaded that cycle).
  - out_data and out_marker_err hold stable while out_valid & !out_ready.
  - A word already held in the output register when the FSM drops to SEARCH drains normally.
- locked is registered and equals (state==LOCKED). Latency from the lock-completing accept to locked=1 is 1 cycle.
- err_count increments by 1 on every acc & !good, in either state, and saturates at all-ones with no wrap.
  - clr_count=1 sets err_count to 0 on the next edge.
  - clr_count has priority over a same-cycle increment; the result is 0.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only while in LOCKED.

Decomposition:
- Shared package direct_codec_pkg holds:
  - DATA_WIDTH and MARKER_WIDTH defaults.
  - MARKER constant 4'b1010.
  - Typedef lock_state_t {SEARCH, LOCKED}.
  - Codeword field slice helpers.
  - The encoder-side reference function {data, MARKER}, also used by the bench.
- One natural sub-module: direct_lock_fsm, containing the state, the run counters and the locked output.
- The output register and err_count stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, locked=0, err_count=0, in_ready=1 asynchronously. After release, the FSM is in SEARCH.
- Lock acquisition: send 12'hAAA, 12'h55A, 12'hF0A, then 12'h3CA with out_ready=1 -> no output for the first 3 words. locked=1 one cycle after the 3rd accept. out_data=8'h3C with out_marker_err=0 one cycle after the 4th accept.
- Backpressure: locked, out_ready=0, send 12'h11A then 12'h22A -> out_data=8'h11 held stable and in_ready=0. Raise out_ready -> 8'h11 then 8'h22 in consecutive cycles, no loss or duplication.
- Single error: locked, send 12'h77B -> out_data=8'h77, out_marker_err=1, err_count=1, locked stays 1. A following 12'h78A is forwarded clean.
- Loss of lock: locked, send 12'h010 then 12'h020 -> both forwarded with out_marker_err=1. locked=0 after the 2nd accept, err_count=2. A subsequent 12'h99A is not forwarded.
- Counter saturation and clear: ERR_CNT_WIDTH=2, send 5 bad words -> err_count=3 (saturated). Assert clr_count in the same cycle as a bad-word accept -> err_count=0.
